pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the program counter and sequences next-PC selection for the single-issue RV32I core: sequential, branch/jal target, jalr target, trap vector.
- Drives the instruction-fetch address with a req/ready handshake.
- Asserts pipeline flush for a fixed number of cycles after every redirect.
- Sits between the EX stage (branch unit and ALU) and instruction memory; replaces ad-hoc PC muxing with one controlled block.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target trap (optional feature only).
- FLUSH_CYCLES, 2, number of cycles flush_o stays high after a redirect; legal range 1..7.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard stall; holds the PC on sequential advance.
- imem_ready_i  in  1  instruction memory accepts the current pc_o this cycle.
- branch_taken_i  in  1  EX resolved a taken branch or jal.
- branch_target_i  in  32  branch/jal target address.
- jalr_sig_i  in  1  EX executing jalr.
- alu_result_i  in  32  jalr target (rs1+imm) from the ALU.
- pc_o  out  32  current fetch address.
- pc_plus4_o  out  32  pc_o + 4; link value.
- imem_req_o  out  1  fetch request valid.
- flush_o  out  1  kill the IF/ID and ID/EX contents.
- redirect_o  out  1  one-cycle pulse on the cycle a redirect is accepted.
- misalign_o  out  1  trap pulse (optional feature only; otherwise tied 0).

Behaviour:
- Reset (rst_i=1 at an edge):
  - pc_o=RESET_PC, imem_req_o=0, flush_o=0, redirect_o=0, misalign_o=0.
  - State=BOOT, flush counter=0.
- States:
  - BOOT: single cycle, imem_req_o=0, then RUN.
  - RUN: imem_req_o=1.
  - FLUSH: imem_req_o=1 (the fetch at the new PC proceeds), flush_o=1.
- Redirect sources, in priority order: jalr_sig_i > branch_taken_i. Both high in the same cycle -> jalr wins.
- jalr target = alu_result_i with bit 0 cleared (alu_result_i & ~32'h1).
- Branch target is used unmodified.
- Redirect timing:
  - Evaluated combinationally in the cycle requested.
  - pc_o takes the target at the next edge.
  - redirect_o=1 in that same request cycle.
  - Accepted in RUN and FLUSH states.
  - Accepted regardless of stall_i and imem_ready_i; redirect overrides stall.
- Redirect also loads the flush counter with FLUSH_CYCLES and enters FLUSH. flush_o is registered: high for exactly FLUSH_CYCLES cycles starting the cycle after acceptance.
- Redirect while in FLUSH: counter reloads to FLUSH_CYCLES (flush extended, not accumulated).
- FLUSH exit: counter decrements each cycle; FLUSH -> RUN when the counter reaches 1 with no new redirect.
- Sequential advance: pc_o <= pc_o+4 only when imem_req_o & imem_ready_i & ~stall_i & no redirect. Otherwise pc_o holds.
- Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000, modulo 2^32, no flag.
- pc_plus4_o is purely combinational from pc_o.
- Redirect requests during BOOT are ignored (pipeline is empty).
- Reset mid-FLUSH or mid-redirect: reset wins; all state and outputs return to reset values at that edge.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect whose selected target has bit 1 set is not taken to the target.
  - Instead pc_o <= TRAP_VEC, misalign_o=1 for one cycle (the request cycle).
  - redirect_o=1 and the flush sequence proceeds as for a normal redirect.
- Undefined:
  - Target bit 1 is ignored; pc_o takes the target as given.
  - misalign_o is constant 0.

Decomposition:
- Shared package (pc_seq_pkg):
  - state enum {BOOT, RUN, FLUSH};
  - next-PC select enum {SEL_SEQ, SEL_BRANCH, SEL_JALR, SEL_TRAP};
  - constant XLEN=32;
  - constant PC_STEP=4.
- One natural sub-module: next_pc_sel, a combinational priority select producing the target and select code.
- The FSM, PC register and flush counter stay in pc_sequencer.

Test Plan:
- Reset, RESET_PC=0, ready=1, no stall -> BOOT one cycle with req=0; then pc_o = 0, 4, 8, 12 on consecutive cycles.
- Stall held 3 cycles at pc_o=0x10 -> pc_o stays 0x10 for 3 cycles, then 0x14; imem_ready_i=0 behaves the same.
- branch_taken_i with target 0x200 at pc_o=0x20 -> redirect_o pulse; next pc_o=0x200; flush_o high exactly 2 cycles; then 0x204, 0x208.
- jalr_sig_i and branch_taken_i together, alu_result_i=0x301, branch target 0x400 -> pc_o=0x300, flush 2 cycles.
- Second branch (target 0x500) one cycle into flush -> pc_o=0x500; flush_o high 3 consecutive cycles total. Separately, pc_o=0xFFFF_FFFC with advance -> 0x0.
- With PC_MISALIGN_TRAP_EN: jalr to 0x102 -> misalign_o pulse, pc_o=TRAP_VEC=0x100. Without the macro -> pc_o=0x102, misalign_o=0. Reset asserted mid-flush -> pc_o=RESET_PC, flush_o=0 the next cycle.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // Sequencer control state.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } seq_state_e;

    // Source chosen for the next program counter.
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JALR   = 2'd2,
        SEL_TRAP   = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority select: jalr > branch/jal > sequential.
// Build option PC_MISALIGN_TRAP_EN: a redirect whose target has bit 1 set
// is diverted to TRAP_VEC and flagged on misalign_o.
module next_pc_sel
    import pc_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic            redir_en_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jalr_sig_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output pc_sel_e         sel_o,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);

`ifndef PC_MISALIGN_TRAP_EN
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;
`endif

    // Pick the redirect source by priority; fall back to the sequential PC.
    always_comb begin
        sel_o      = SEL_SEQ;
        target_o   = pc_plus4_i;
        misalign_o = 1'b0;
        if (redir_en_i && jalr_sig_i) begin
            sel_o    = SEL_JALR;
            target_o = alu_result_i & ~32'h1;
        end else if (redir_en_i && branch_taken_i) begin
            sel_o    = SEL_BRANCH;
            target_o = branch_target_i;
        end
`ifdef PC_MISALIGN_TRAP_EN
        if (sel_o != SEL_SEQ && target_o[1]) begin
            sel_o      = SEL_TRAP;
            target_o   = TRAP_VEC;
            misalign_o = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-issue RV32I core.
// Owns the PC, issues fetch requests, handles branch/jalr redirects and
// holds flush_o high for FLUSH_CYCLES cycles after each redirect.
// Build option PC_MISALIGN_TRAP_EN enables the misaligned-target trap.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC     = 32'h0000_0100,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            imem_ready_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jalr_sig_i,
    input  logic [XLEN-1:0] alu_result_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            imem_req_o,
    output logic            flush_o,
    output logic            redirect_o,
    output logic            misalign_o
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            flush_q, flush_d;

    pc_sel_e         sel;
    logic [XLEN-1:0] target;
    logic            misalign;
    logic            redirect;
    logic            advance;

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + PC_STEP;
    assign imem_req_o = (state_q != BOOT);
    assign flush_o    = flush_q;
    assign redirect_o = redirect;
    assign misalign_o = misalign;

    // Redirects are ignored in BOOT because the pipeline is still empty.
    next_pc_sel #(
        .TRAP_VEC (TRAP_VEC)
    ) u_next_pc_sel (
        .redir_en_i      (imem_req_o),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jalr_sig_i      (jalr_sig_i),
        .alu_result_i    (alu_result_i),
        .pc_plus4_i      (pc_plus4_o),
        .sel_o           (sel),
        .target_o        (target),
        .misalign_o      (misalign)
    );

    assign redirect = (sel != SEL_SEQ);
    assign advance  = imem_req_o && imem_ready_i && !stall_i;

    // Next-state, next-PC and flush-counter logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;

        if (redirect) begin
            pc_d = target;
        end else if (advance) begin
            pc_d = pc_plus4_o;
        end

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                cnt_d   = 3'd0;
                flush_d = 1'b0;
            end
            RUN: begin
                if (redirect) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                    flush_d = 1'b1;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    cnt_d   = FLUSH_LOAD;
                    flush_d = 1'b1;
                end else if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = BOOT;
                cnt_d   = 3'd0;
                flush_d = 1'b0;
            end
        endcase
    end

    // State, PC and flush registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 3'd0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

endmodule
